// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes and mode helpers.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_t;

  function automatic logic is_shift(input usr_mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a registered at-max flag; counts shifts since the last load/clear/reset.
module sat_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_nxt;

  // Sticks at MAX rather than wrapping.
  always_comb begin
    cnt_nxt = count;
    if (count != MAX_V) cnt_nxt = count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (inc) begin
      count  <= cnt_nxt;
      at_max <= (cnt_nxt == MAX_V);
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with hold / shift-left / shift-right / parallel-load modes,
// synchronous clear, clock enable and a saturating shift counter with done flag.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  usr_mode_t        m;
  logic [WIDTH-1:0] q_nxt;
  logic             cnt_inc;
  logic             cnt_clr;

  assign m = usr_mode_t'(mode);

  // Next-q mux; only consulted when en is high.
  always_comb begin
    q_nxt = q;
    unique case (m)
      MODE_HOLD: q_nxt = q;
      MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
      MODE_LOAD: q_nxt = d;
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      q <= RESET_VAL;
    else if (clr) q <= '0;
    else if (en)  q <= q_nxt;
  end

  // A load restarts the shift count just like a clear does.
  assign cnt_inc = en & is_shift(m);
  assign cnt_clr = clr | (en & (m == MODE_LOAD));

  sat_counter #(
    .MAX   (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (count),
    .at_max (done)
  );

  assign sout = (m == MODE_SHL) ? q[WIDTH-1] : q[0];

endmodule
